median_arbiter: RTL

//   Shares one 3-input `median` functional unit between NUM_REQ requesters.
//   - Runs the unit's rst_n bring-up sequence after reset.
//   - Grants requests round-robin and drives the unit's word0..word2 from a latched copy.
//   - Captures median_word after MED_LAT cycles and returns it to the granted requester.
//   - Sits between median_filter-style kernels and a single shared median instance.

---
 rtl/median_arbiter_if.sv | 22 ++
 rtl/median_arbiter.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/median_arbiter_if.sv
// rtl/median_arbiter_if.sv - requester-side request/response bus of the median arbiter
interface median_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 32
);
    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ-1:0]         req_ready;
    logic [NUM_REQ*3*WIDTH-1:0] req_words;
    logic [NUM_REQ-1:0]         resp_valid;
    logic [NUM_REQ-1:0]         resp_ready;
    logic [WIDTH-1:0]           resp_data;

    modport slave (
        input  req_valid, req_words, resp_ready,
        output req_ready, resp_valid, resp_data
    );

    modport master (
        output req_valid, req_words, resp_ready,
        input  req_ready, resp_valid, resp_data
    );
endinterface

// File: rtl/median_arbiter.sv
// rtl/median_arbiter.sv - round-robin sharing of one 3-input median unit among NUM_REQ requesters
module median_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int WIDTH    = 32,
    parameter int MED_LAT  = 1,
    parameter int INIT_LOW = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    median_arbiter_if.slave  bus,
    output logic             m_rst_n,
    output logic [WIDTH-1:0] m_word0,
    output logic [WIDTH-1:0] m_word1,
    output logic [WIDTH-1:0] m_word2,
    input  logic [WIDTH-1:0] m_median_word,
    output logic             init_done,
    output logic             busy
);
    localparam int PTR_W   = $clog2(NUM_REQ);
    localparam int CNT_MAX = (INIT_LOW > MED_LAT) ? INIT_LOW : MED_LAT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_INIT_HI,
        S_INIT_LO,
        S_INIT_HI2,
        S_IDLE,
        S_EXEC,
        S_RESP
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]   grant_q, grant_d;
    logic [WIDTH-1:0]   word0_q, word0_d;
    logic [WIDTH-1:0]   word1_q, word1_d;
    logic [WIDTH-1:0]   word2_q, word2_d;
    logic [WIDTH-1:0]   resp_data_q, resp_data_d;
    logic               init_done_q, init_done_d;

    logic               any_valid;
    logic [PTR_W-1:0]   grant_idx;
    logic [3*WIDTH-1:0] sel_words;

    // Search starts at rr_ptr so the last-served requester is considered last.
    always_comb begin
        int idx;
        idx       = 0;
        any_valid = 1'b0;
        grant_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_ptr_q) + k) % NUM_REQ;
            if (!any_valid && bus.req_valid[idx]) begin
                any_valid = 1'b1;
                grant_idx = PTR_W'(idx);
            end
        end
    end

    always_comb begin
        int base;
        base      = int'(grant_idx) * 3 * WIDTH;
        sel_words = bus.req_words[base +: 3*WIDTH];
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        rr_ptr_d       = rr_ptr_q;
        grant_d        = grant_q;
        word0_d        = word0_q;
        word1_d        = word1_q;
        word2_d        = word2_q;
        resp_data_d    = resp_data_q;
        init_done_d    = init_done_q;
        bus.req_ready  = '0;
        bus.resp_valid = '0;
        case (state_q)
            S_INIT_HI: begin
                cnt_d   = '0;
                state_d = S_INIT_LO;
            end
            S_INIT_LO: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(INIT_LOW - 1)) begin
                    cnt_d   = '0;
                    state_d = S_INIT_HI2;
                end
            end
            S_INIT_HI2: begin
                init_done_d = 1'b1;
                state_d     = S_IDLE;
            end
            S_IDLE: begin
                if (any_valid) begin
                    bus.req_ready[grant_idx] = 1'b1;
                    word0_d  = sel_words[0*WIDTH +: WIDTH];
                    word1_d  = sel_words[1*WIDTH +: WIDTH];
                    word2_d  = sel_words[2*WIDTH +: WIDTH];
                    grant_d  = grant_idx;
                    cnt_d    = '0;
                    rr_ptr_d = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + PTR_W'(1);
                    state_d  = S_EXEC;
                end
            end
            S_EXEC: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(MED_LAT - 1)) begin
                    resp_data_d = m_median_word;
                    state_d     = S_RESP;
                end
            end
            S_RESP: begin
                bus.resp_valid[grant_q] = 1'b1;
                if (bus.resp_ready[grant_q]) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_INIT_HI;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_INIT_HI;
            cnt_q       <= '0;
            rr_ptr_q    <= '0;
            grant_q     <= '0;
            word0_q     <= '0;
            word1_q     <= '0;
            word2_q     <= '0;
            resp_data_q <= '0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_q     <= grant_d;
            word0_q     <= word0_d;
            word1_q     <= word1_d;
            word2_q     <= word2_d;
            resp_data_q <= resp_data_d;
            init_done_q <= init_done_d;
        end
    end

    assign m_rst_n       = (state_q != S_INIT_LO);
    assign busy          = (state_q != S_IDLE);
    assign init_done     = init_done_q;
    assign m_word0       = word0_q;
    assign m_word1       = word1_q;
    assign m_word2       = word2_q;
    assign bus.resp_data = resp_data_q;
endmodule
